// File: rtl/alu_pkg.sv
// alu_pkg: opcode map and FSM state type shared by the multicycle ALU
package alu_pkg;
    localparam logic [3:0] OP_ZERO   = 4'b1111;
    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0011;
    localparam logic [3:0] OP_AND    = 4'b1000;
    localparam logic [3:0] OP_OR     = 4'b1001;
    localparam logic [3:0] OP_NOT    = 4'b1011;
    localparam logic [3:0] OP_XOR    = 4'b1010;
    localparam logic [3:0] OP_SHL1   = 4'b1101;
    localparam logic [3:0] OP_PASSA0 = 4'b0100;
    localparam logic [3:0] OP_PASSA1 = 4'b0110;
    localparam logic [3:0] OP_SLL    = 4'b1100;
    localparam logic [3:0] OP_SRL    = 4'b1110;
    localparam logic [3:0] OP_MUL    = 4'b0101;
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} alu_state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one step per cycle, done one cycle after the last step
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;
    logic             run;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0] mplier;
    assign done = run && cnt == CW'(WIDTH);
    assign prod = acc[WIDTH-1:0];
    // the full double-width product is kept so overflow needs no extra logic
    assign ovf  = |acc[2*WIDTH-1:WIDTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run    <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            run    <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (done) begin
            run    <= 1'b0;
        end else if (run) begin
            acc    <= mplier[0] ? acc + mcand : acc;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: valid/ready ALU with registered result and flags, iterative multiply
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] reg_1,
    input  logic [WIDTH-1:0] reg_2,
    input  logic [3:0]       alu_opsel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_res,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int SHAMT_W = $clog2(WIDTH);
    alu_state_t state, nstate;
    logic             accept, is_mul, mul_done, mul_ovf, c, v;
    logic [WIDTH-1:0] mul_res, res;
    logic [WIDTH:0]   sum, diff, sll_x, srl_x;
    logic [SHAMT_W-1:0] shamt;
    assign is_mul = alu_opsel == OP_MUL;
    assign accept = in_valid && in_ready;
    assign shamt  = reg_2[SHAMT_W-1:0];
    assign sum    = {1'b0, reg_1} + {1'b0, reg_2};
    assign diff   = {1'b0, reg_1} - {1'b0, reg_2};
    // one guard bit on each side catches the last bit shifted out
    assign sll_x  = {1'b0, reg_1} << shamt;
    assign srl_x  = {reg_1, 1'b0} >> shamt;
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && is_mul),
        .a     (reg_1),
        .b     (reg_2),
        .done  (mul_done),
        .prod  (mul_res),
        .ovf   (mul_ovf)
    );
    always_comb begin
        nstate    = state;
        in_ready  = state == IDLE || (state == HOLD && out_ready);
        out_valid = state == HOLD;
        case (state)
            IDLE:    if (in_valid) nstate = is_mul ? BUSY : HOLD;
            BUSY:    if (mul_done) nstate = HOLD;
            HOLD:    if (out_ready) nstate = !in_valid ? IDLE : is_mul ? BUSY : HOLD;
            default: nstate = IDLE;
        endcase
    end
    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (alu_opsel)
            OP_ADD: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = reg_1[WIDTH-1] == reg_2[WIDTH-1] && sum[WIDTH-1] != reg_1[WIDTH-1];
            end
            OP_SUB: begin
                res = diff[WIDTH-1:0];
                c   = !diff[WIDTH];
                v   = reg_1[WIDTH-1] != reg_2[WIDTH-1] && diff[WIDTH-1] != reg_1[WIDTH-1];
            end
            OP_AND:               res = reg_1 & reg_2;
            OP_OR:                res = reg_1 | reg_2;
            OP_NOT:               res = ~reg_1;
            OP_XOR:               res = reg_1 ^ reg_2;
            OP_PASSA0, OP_PASSA1: res = reg_1;
            OP_SHL1: begin
                res = {reg_1[WIDTH-2:0], 1'b0};
                c   = reg_1[WIDTH-1];
            end
            OP_SLL: begin
                res = sll_x[WIDTH-1:0];
                c   = sll_x[WIDTH];
            end
            OP_SRL: begin
                res = srl_x[WIDTH:1];
                c   = srl_x[0];
            end
            default:              res = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            alu_res <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
        end else begin
            state <= nstate;
            if (accept && !is_mul) begin
                alu_res <= res;
                flag_z  <= res == '0;
                flag_n  <= res[WIDTH-1];
                flag_c  <= c;
                flag_v  <= v;
            end else if (mul_done) begin
                alu_res <= mul_res;
                flag_z  <= mul_res == '0;
                flag_n  <= mul_res[WIDTH-1];
                flag_c  <= mul_ovf;
                flag_v  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench with directed corner cases and randomized traffic
module tb_alu_multicycle;
    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [31:0] reg_1 = 0, reg_2 = 0;
    logic [3:0]  alu_opsel = 0;
    logic        in_ready, out_valid, flag_z, flag_n, flag_c, flag_v;
    logic [31:0] alu_res;
    int checks = 0, errors = 0;
    int bp_mode = 0;
    typedef struct packed {
        logic [31:0] res;
        logic z, n, c, v;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .reg_1(reg_1), .reg_2(reg_2), .alu_opsel(alu_opsel), .out_valid(out_valid),
        .out_ready(out_ready), .alu_res(alu_res), .flag_z(flag_z), .flag_n(flag_n),
        .flag_c(flag_c), .flag_v(flag_v)
    );

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        logic [63:0] w;
        int amt = int'(b[4:0]);
        e = '0;
        case (op)
            4'b0000: begin
                w = 64'(a) + 64'(b); e.res = w[31:0]; e.c = w[32];
                s = sa + sb; e.v = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
            4'b0011: begin
                e.res = a - b; e.c = a >= b;
                s = sa - sb; e.v = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
            4'b1000: e.res = a & b;
            4'b1001: e.res = a | b;
            4'b1011: e.res = ~a;
            4'b1010: e.res = a ^ b;
            4'b1101: begin e.res = a * 2; e.c = a[31]; end
            4'b0100, 4'b0110: e.res = a;
            4'b1100: begin e.res = a << amt; e.c = amt != 0 && a[32-amt]; end
            4'b1110: begin e.res = a >> amt; e.c = amt != 0 && a[amt-1]; end
            4'b0101: begin w = 64'(a) * 64'(b); e.res = w[31:0]; e.c = w[63:32] != 0; end
            default: e.res = 0;
        endcase
        e.z = e.res == 0;
        e.n = e.res[31];
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int waits);
        in_valid = 1; alu_opsel = op; reg_1 = a; reg_2 = b; waits = 0;
        #1;
        while (!in_ready && waits < 200) begin
            @(negedge clk); #1; waits++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: op %b never accepted", op);
        end else q.push_back(model(op, a, b));
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'($urandom_range(40));
            default: return $urandom;
        endcase
    endfunction

    initial forever begin
        @(negedge clk);
        out_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? ($urandom_range(3) != 0) : 1'b0;
    end

    initial forever begin
        exp_t e;
        @(negedge clk); #2;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got %0h expected none", alu_res);
            end else begin
                e = q.pop_front();
                chk("result{res,z,n,c,v}", 64'({alu_res, flag_z, flag_n, flag_c, flag_v}), 64'(e));
            end
        end
    end

    initial begin
        int w, wsum, k;
        logic bad;
        logic [35:0] held;
        logic [3:0] ops[16];
        for (int i = 0; i < 16; i++) ops[i] = 4'(i);
        #7;
        chk("reset_out_valid", 64'(out_valid), 0);
        chk("reset_in_ready", 64'(in_ready), 1);
        chk("reset_res_flags", 64'({alu_res, flag_z, flag_n, flag_c, flag_v}), 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        wsum = 0;
        issue(4'b0000, 32'hFFFFFFFF, 32'h1, w); wsum += w;
        issue(4'b0000, 32'h7FFFFFFF, 32'h1, w); wsum += w;
        issue(4'b0011, 32'h3, 32'h5, w); wsum += w;
        issue(4'b1100, 32'h80000001, 32'h1, w); wsum += w;
        issue(4'b1110, 32'h3, 32'd33, w); wsum += w;
        issue(4'b1101, 32'h40000000, 32'h0, w); wsum += w;
        issue(4'b0010, 32'h1234, 32'h5678, w); wsum += w;
        chk("throughput_stalls", 64'(wsum), 0);
        issue(4'b0101, 32'h10000, 32'h10000, w);
        issue(4'b0101, 32'h0, 32'hFFFFFFFF, w);
        in_valid = 0;
        repeat (40) @(negedge clk);
        issue(4'b0101, 32'd7, 32'd6, w);
        in_valid = 0;
        k = 1; bad = 0;
        #2;
        while (!out_valid && k < 100) begin
            bad |= in_ready;
            @(negedge clk); #2; k++;
        end
        chk("mul_latency", 64'(k - 1), 33);
        chk("busy_in_ready_low", 64'(bad), 0);
        foreach (ops[i]) issue(ops[i], 32'hA5A5F00F, 32'h0FF0_1234, w);
        in_valid = 0;
        repeat (40) @(negedge clk);
        bp_mode = 2;
        @(negedge clk);
        issue(4'b0000, 32'h7FFFFFFF, 32'h1, w);
        in_valid = 0;
        #2;
        held = {alu_res, flag_z, flag_n, flag_c, flag_v};
        bad = 0;
        repeat (5) begin
            @(negedge clk); #2;
            bad |= {alu_res, flag_z, flag_n, flag_c, flag_v} != held || !out_valid || in_ready;
        end
        chk("backpressure_hold", 64'(bad), 0);
        bp_mode = 0;
        repeat (3) @(negedge clk);
        chk("backpressure_drain", 64'(q.size()), 0);
        issue(4'b0101, 32'd123, 32'd456, w);
        in_valid = 0;
        repeat (9) @(negedge clk);
        #3 rst_n = 0;
        #1;
        chk("rst_mul_out_valid", 64'(out_valid), 0);
        chk("rst_mul_in_ready", 64'(in_ready), 1);
        chk("rst_mul_res", 64'({alu_res, flag_z, flag_n, flag_c, flag_v}), 0);
        q.delete();
        @(negedge clk); rst_n = 1;
        bad = 0;
        repeat (40) begin
            @(negedge clk); #2; bad |= out_valid;
        end
        chk("rst_mul_discard", 64'(bad), 0);
        bp_mode = 2;
        @(negedge clk);
        issue(4'b0000, 32'd5, 32'd6, w);
        in_valid = 0;
        #3 rst_n = 0;
        #1;
        chk("rst_hold_out_valid", 64'(out_valid), 0);
        chk("rst_hold_res", 64'(alu_res), 0);
        q.delete();
        bp_mode = 0;
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        bp_mode = 1;
        repeat (250) begin
            issue(ops[$urandom_range(15)], rnd_operand(), rnd_operand(), w);
            if ($urandom_range(3) == 0) begin
                in_valid = 0;
                repeat ($urandom_range(2)) @(negedge clk);
            end
        end
        in_valid = 0;
        bp_mode = 0;
        k = 0;
        while (q.size() != 0 && k < 500) begin
            @(negedge clk); k++;
        end
        repeat (2) @(negedge clk);
        chk("final_drain", 64'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
